router_fsm: RTL and testbench

- Packet-receive controller for the 1x3 router. It tracks the header, payload, parity and full/stall phases of each input packet.
- It produces the strobes the register stage and synchronizer need: `detect_add`, `write_enb_reg`, load-phase flags, `busy` and `rst_int_reg`.
- It sits between the input port and the register/synchronizer pair.
- It monitors the target FIFO's empty status and the per-port soft resets to abort or stall packets.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_fsm_if.sv | 43 ++++
 rtl/router_fsm.sv | 113 +++++++++++
 tb/tb_router_fsm.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router receive controller.
package router_pkg;

   localparam int ADDR_W    = 2;
   localparam int NUM_PORTS = 3;

   localparam logic [1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } router_fsm_state_e;

endpackage

// File: rtl/router_fsm_if.sv
// Input-port / register-stage / synchronizer signals seen by the router FSM.
interface router_fsm_if #(
   parameter int ADDR_W = 2
);
   logic              pkt_valid;
   logic [ADDR_W-1:0] data_in;
   logic              fifo_full;
   logic              fifo_empty_0;
   logic              fifo_empty_1;
   logic              fifo_empty_2;
   logic              soft_reset_0;
   logic              soft_reset_1;
   logic              soft_reset_2;
   logic              parity_done;
   logic              low_pkt_valid;

   logic detect_add;
   logic lfd_state;
   logic ld_state;
   logic laf_state;
   logic full_state;
   logic write_enb_reg;
   logic rst_int_reg;
   logic busy;

   modport master (
      output pkt_valid, data_in, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state,
      input  full_state, write_enb_reg, rst_int_reg, busy
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state,
      output full_state, write_enb_reg, rst_int_reg, busy
   );
endinterface

// File: rtl/router_fsm.sv
// Packet-receive controller: header, payload, parity and full/stall
// phases of each input packet, with Moore strobes for the datapath.
module router_fsm #(
   parameter int ADDR_W = 2
) (
   input logic        clk,
   input logic        rst,
   router_fsm_if.slave bus
);
   import router_pkg::*;

   router_fsm_state_e state_q, state_d;

   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ADDR_W-1:0]    sel_addr;
   logic [NUM_PORTS-1:0] empty_vec;
   logic [NUM_PORTS-1:0] soft_vec;
   logic                 sel_empty;
   logic                 soft_hit;
   logic                 addr_ok;

   assign empty_vec = {bus.fifo_empty_2,
                       bus.fifo_empty_1,
                       bus.fifo_empty_0};
   assign soft_vec  = {bus.soft_reset_2,
                       bus.soft_reset_1,
                       bus.soft_reset_0};

   // header not yet latched while decoding, so look at data_in directly
   assign sel_addr = (state_q == DECODE_ADDRESS) ?
                     bus.data_in : addr_q;
   assign addr_ok  = (bus.data_in != ADDR_INVALID);

   always_comb begin
      sel_empty = 1'b0;
      soft_hit  = 1'b0;
      if (int'(sel_addr) < NUM_PORTS)
         sel_empty = empty_vec[sel_addr];
      if (int'(addr_q) < NUM_PORTS)
         soft_hit = soft_vec[addr_q] &&
                    (state_q != DECODE_ADDRESS);
   end

   always_comb begin
      addr_d = addr_q;
      if (state_q == DECODE_ADDRESS && bus.pkt_valid)
         addr_d = bus.data_in;
   end

   always_comb begin
      state_d = state_q;
      if (soft_hit) begin
         state_d = DECODE_ADDRESS;
      end else begin
         unique case (state_q)
            DECODE_ADDRESS:
               if (bus.pkt_valid && addr_ok)
                  state_d = sel_empty ? LOAD_FIRST_DATA
                                      : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
               state_d = LOAD_DATA;
            LOAD_DATA:
               if (bus.fifo_full)
                  state_d = FIFO_FULL_STATE;
               else if (!bus.pkt_valid)
                  state_d = LOAD_PARITY;
            FIFO_FULL_STATE:
               if (!bus.fifo_full)
                  state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
               if (bus.parity_done)
                  state_d = DECODE_ADDRESS;
               else if (bus.low_pkt_valid)
                  state_d = LOAD_PARITY;
               else
                  state_d = LOAD_DATA;
            LOAD_PARITY:
               state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
               state_d = bus.fifo_full ? FIFO_FULL_STATE
                                       : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
               if (sel_empty)
                  state_d = LOAD_FIRST_DATA;
            default:
               state_d = DECODE_ADDRESS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   assign bus.detect_add    = (state_q == DECODE_ADDRESS);
   assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
   assign bus.ld_state      = (state_q == LOAD_DATA);
   assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
   assign bus.full_state    = (state_q == FIFO_FULL_STATE);
   assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
   assign bus.write_enb_reg = (state_q == LOAD_DATA) ||
                              (state_q == LOAD_AFTER_FULL) ||
                              (state_q == LOAD_PARITY);
   assign bus.busy          = (state_q != DECODE_ADDRESS) &&
                              (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios plus random traffic
// compared against a phase-level reference model.
module tb_router_fsm;

   logic clk = 1'b0;
   logic rst;

   router_fsm_if #(.ADDR_W(2)) bus ();

   router_fsm #(.ADDR_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // {detect, lfd, ld, laf, full, wr_en, rst_int, busy}
   localparam logic [7:0] O_DA  = 8'b1000_0000;
   localparam logic [7:0] O_LFD = 8'b0100_0001;
   localparam logic [7:0] O_LD  = 8'b0010_0100;
   localparam logic [7:0] O_LAF = 8'b0001_0101;
   localparam logic [7:0] O_FUL = 8'b0000_1001;
   localparam logic [7:0] O_LP  = 8'b0000_0101;
   localparam logic [7:0] O_CPE = 8'b0000_0011;
   localparam logic [7:0] O_WTE = 8'b0000_0001;

   logic [7:0] o;
   assign o = {bus.detect_add, bus.lfd_state, bus.ld_state,
               bus.laf_state, bus.full_state, bus.write_enb_reg,
               bus.rst_int_reg, bus.busy};

   task automatic check(input string tag,
                        input logic [7:0] got,
                        input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   // reference model: packet phase plus latched destination
   typedef enum int {
      M_IDLE, M_HDR, M_PAY, M_STALL, M_RESUME,
      M_PAR, M_CHK, M_WAIT
   } mphase_e;

   mphase_e mp = M_IDLE;
   int      ma = 0;

   function automatic logic [7:0] exp_of(input mphase_e p);
      case (p)
         M_IDLE:   return O_DA;
         M_HDR:    return O_LFD;
         M_PAY:    return O_LD;
         M_RESUME: return O_LAF;
         M_STALL:  return O_FUL;
         M_PAR:    return O_LP;
         M_CHK:    return O_CPE;
         default:  return O_WTE;
      endcase
   endfunction

   function automatic bit empty_of(input int a);
      if (a == 0) return bus.fifo_empty_0;
      if (a == 1) return bus.fifo_empty_1;
      if (a == 2) return bus.fifo_empty_2;
      return 1'b0;
   endfunction

   function automatic bit soft_of(input int a);
      if (a == 0) return bus.soft_reset_0;
      if (a == 1) return bus.soft_reset_1;
      if (a == 2) return bus.soft_reset_2;
      return 1'b0;
   endfunction

   task automatic model_step();
      mphase_e np;
      int din;
      din = int'(bus.data_in);
      np = mp;
      if (rst) begin
         mp = M_IDLE;
         ma = 0;
         return;
      end
      if (mp != M_IDLE && soft_of(ma)) begin
         np = M_IDLE;
      end else if (mp == M_IDLE) begin
         if (bus.pkt_valid && din < 3)
            np = empty_of(din) ? M_HDR : M_WAIT;
      end else if (mp == M_HDR) begin
         np = M_PAY;
      end else if (mp == M_PAY) begin
         if (bus.fifo_full) np = M_STALL;
         else if (!bus.pkt_valid) np = M_PAR;
      end else if (mp == M_STALL) begin
         if (!bus.fifo_full) np = M_RESUME;
      end else if (mp == M_RESUME) begin
         if (bus.parity_done) np = M_IDLE;
         else if (bus.low_pkt_valid) np = M_PAR;
         else np = M_PAY;
      end else if (mp == M_PAR) begin
         np = M_CHK;
      end else if (mp == M_CHK) begin
         np = bus.fifo_full ? M_STALL : M_IDLE;
      end else begin
         if (empty_of(ma)) np = M_HDR;
      end
      if (mp == M_IDLE && bus.pkt_valid) ma = din;
      mp = np;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check("model", o, exp_of(mp));
   endtask

   task automatic idle_inputs();
      bus.pkt_valid     = 1'b0;
      bus.data_in       = 2'd0;
      bus.fifo_full     = 1'b0;
      bus.fifo_empty_0  = 1'b1;
      bus.fifo_empty_1  = 1'b1;
      bus.fifo_empty_2  = 1'b1;
      bus.soft_reset_0  = 1'b0;
      bus.soft_reset_1  = 1'b0;
      bus.soft_reset_2  = 1'b0;
      bus.parity_done   = 1'b0;
      bus.low_pkt_valid = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      check("reset", o, O_DA);
      rst = 1'b0;

      // normal packet to port 1
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd1;
      cyc();
      check("norm_lfd", o, O_LFD);
      for (int i = 0; i < 4; i++) begin
         bus.data_in = 2'($urandom);
         cyc();
         check("norm_ld", o, O_LD);
      end
      bus.pkt_valid = 1'b0;
      cyc();
      check("norm_lp", o, O_LP);
      cyc();
      check("norm_cpe", o, O_CPE);
      cyc();
      check("norm_da", o, O_DA);

      // destination FIFO 2 busy
      bus.pkt_valid    = 1'b1;
      bus.data_in      = 2'd2;
      bus.fifo_empty_2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("wte", o, O_WTE);
      end
      bus.fifo_empty_2 = 1'b1;
      cyc();
      check("wte_lfd", o, O_LFD);
      cyc();
      bus.pkt_valid = 1'b0;
      cyc();
      cyc();
      cyc();
      check("wte_done", o, O_DA);

      // full stall and resume
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd0;
      cyc();
      cyc();
      bus.fifo_full = 1'b1;
      cyc();
      check("full", o, O_FUL);
      cyc();
      check("full_hold", o, O_FUL);
      bus.fifo_full = 1'b0;
      cyc();
      check("laf", o, O_LAF);
      cyc();
      check("laf_ld", o, O_LD);
      bus.fifo_full = 1'b1;
      cyc();
      bus.fifo_full = 1'b0;
      cyc();
      check("laf2", o, O_LAF);
      bus.low_pkt_valid = 1'b1;
      cyc();
      check("laf_lp", o, O_LP);
      bus.low_pkt_valid = 1'b0;
      bus.pkt_valid     = 1'b0;
      cyc();
      cyc();
      check("full_done", o, O_DA);

      // full beats pkt_valid fall; parity_done ends the packet
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd1;
      cyc();
      cyc();
      bus.fifo_full = 1'b1;
      bus.pkt_valid = 1'b0;
      cyc();
      check("full_wins", o, O_FUL);
      bus.fifo_full   = 1'b0;
      bus.parity_done = 1'b1;
      cyc();
      cyc();
      check("pdone_da", o, O_DA);
      bus.parity_done = 1'b0;

      // soft reset while waiting on port 0
      bus.pkt_valid    = 1'b1;
      bus.data_in      = 2'd0;
      bus.fifo_empty_0 = 1'b0;
      cyc();
      bus.soft_reset_1 = 1'b1;
      cyc();
      check("sr_other", o, O_WTE);
      bus.soft_reset_1 = 1'b0;
      bus.soft_reset_0 = 1'b1;
      bus.pkt_valid    = 1'b0;
      cyc();
      check("sr_own", o, O_DA);
      bus.soft_reset_0 = 1'b0;
      bus.fifo_empty_0 = 1'b1;

      // address 3 is dropped
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd3;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("addr3", o, O_DA);
      end
      bus.pkt_valid = 1'b0;

      // random traffic
      for (int i = 0; i < 600; i++) begin
         rst               = ($urandom_range(0, 59) == 0);
         bus.pkt_valid     = ($urandom_range(0, 9) < 7);
         bus.data_in       = 2'($urandom);
         bus.fifo_full     = ($urandom_range(0, 3) == 0);
         bus.fifo_empty_0  = ($urandom_range(0, 9) < 6);
         bus.fifo_empty_1  = ($urandom_range(0, 9) < 6);
         bus.fifo_empty_2  = ($urandom_range(0, 9) < 6);
         bus.soft_reset_0  = ($urandom_range(0, 24) == 0);
         bus.soft_reset_1  = ($urandom_range(0, 24) == 0);
         bus.soft_reset_2  = ($urandom_range(0, 24) == 0);
         bus.parity_done   = ($urandom_range(0, 7) == 0);
         bus.low_pkt_valid = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
